// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry decode queue
//
// Owns the fetch PC, issues word reads over a valid/ready request channel,
// collects in-order responses into a 2-entry {inst, pc} queue for decode,
// and restarts at a new PC on redirect while discarding stale responses.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr     fetch request channel (word aligned)
//   imem_rsp_valid/data           in-order response, always accepted
//   redirect, redirect_pc         branch redirect from decode
//   dec_valid/ready/inst/pc       queue head presented to decode
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_inst,
   output logic [31:0] dec_pc
);

   logic [31:0] fpc;
   logic [31:0] rpc;
   logic [1:0]  outst;
   logic [1:0]  drop;
   logic [1:0]  cnt;
   logic [31:0] q_inst [2];
   logic [31:0] q_pc   [2];

   logic        deq;
   logic        hs;
   logic        rsp_keep;
   logic        wr_slot;
   logic [2:0]  credit_use;
   logic [31:0] redirect_base;

   always_comb begin
      deq           = dec_valid & dec_ready;
      // Outstanding requests plus queued entries may never exceed the queue
      // depth, so every response has a slot even if decode stalls.
      credit_use    = {1'b0, outst} + {1'b0, cnt} - {2'b00, deq};
      imem_req_valid = !rst && !redirect && (credit_use < 3'd2);
      imem_req_addr = fpc;
      hs            = imem_req_valid & imem_req_ready;
      rsp_keep      = imem_rsp_valid && (drop == 2'd0);
      // Slot for a new entry is counted after this cycle's pop.
      wr_slot       = (cnt - {1'b0, deq}) != 2'd0;
      redirect_base = redirect_pc & ~32'h3;
      dec_valid     = cnt != 2'd0;
      dec_inst      = dec_valid ? q_inst[0] : 32'h0;
      dec_pc        = dec_valid ? q_pc[0]   : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc       <= RESET_PC;
         rpc       <= RESET_PC;
         outst     <= 2'd0;
         drop      <= 2'd0;
         cnt       <= 2'd0;
         q_inst[0] <= 32'h0;
         q_inst[1] <= 32'h0;
         q_pc[0]   <= 32'h0;
         q_pc[1]   <= 32'h0;
      end else if (redirect) begin
         // Everything still in flight after this cycle's response is stale.
         fpc   <= redirect_base;
         rpc   <= redirect_base;
         cnt   <= 2'd0;
         outst <= outst - {1'b0, imem_rsp_valid};
         drop  <= outst - {1'b0, imem_rsp_valid};
      end else begin
         if (hs) begin
            fpc <= fpc + 32'd4;
         end
         outst <= outst + {1'b0, hs} - {1'b0, imem_rsp_valid};
         if (imem_rsp_valid && (drop != 2'd0)) begin
            drop <= drop - 2'd1;
         end
         if (deq) begin
            q_inst[0] <= q_inst[1];
            q_pc[0]   <= q_pc[1];
         end
         // Written after the shift so a same-cycle enqueue wins its slot.
         if (rsp_keep) begin
            rpc                   <= rpc + 32'd4;
            q_inst[32'(wr_slot)]  <= imem_rsp_data;
            q_pc[32'(wr_slot)]    <= rpc;
         end
         cnt <= cnt + {1'b0, rsp_keep} - {1'b0, deq};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(imem_rsp_valid && (outst == 2'd0)));
         assert (!(!redirect && rsp_keep && !deq && (cnt == 2'd2)));
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5C3_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;

   logic        hi_req_valid;
   logic [31:0] hi_req_addr;
   logic        hi_dec_valid;
   logic [31:0] hi_dec_inst;
   logic [31:0] hi_dec_pc;
   logic        hi_zero;
   logic [31:0] hi_zero32;

   fetch_unit u_dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_inst       (dec_inst),
      .dec_pc         (dec_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (hi_req_valid),
      .imem_req_ready (hi_zero),
      .imem_req_addr  (hi_req_addr),
      .imem_rsp_valid (hi_zero),
      .imem_rsp_data  (hi_zero32),
      .redirect       (hi_zero),
      .redirect_pc    (hi_zero32),
      .dec_valid      (hi_dec_valid),
      .dec_ready      (hi_zero),
      .dec_inst       (hi_dec_inst),
      .dec_pc         (hi_dec_pc)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          lat = 1;
   int          hs_cnt = 0;
   int          deq_cnt = 0;
   logic [31:0] model_fpc = 32'h0;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   logic [31:0] exp_pc    [$];
   logic [31:0] exp_inst  [$];

   logic        s_req_valid, s_dec_valid, s_hi_valid, s_hi_dec_valid;
   logic [31:0] s_req_addr, s_dec_pc, s_dec_inst, s_hi_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      logic [31:0] pc;
      for (int i = 0; i < n; i++) begin
         pc = start + 32'(4 * i);
         exp_pc.push_back(pc);
         exp_inst.push_back(pc ^ KEY);
      end
   endtask

   task automatic clear_exp();
      exp_pc.delete();
      exp_inst.delete();
   endtask

   // Sample the cycle at the falling edge, then advance memory after the rising edge.
   task automatic cycle();
      logic [31:0] e_pc, e_inst;
      @(negedge clk);
      s_req_valid    = imem_req_valid;
      s_req_addr     = imem_req_addr;
      s_dec_valid    = dec_valid;
      s_dec_pc       = dec_pc;
      s_dec_inst     = dec_inst;
      s_hi_valid     = hi_req_valid;
      s_hi_addr      = hi_req_addr;
      s_hi_dec_valid = hi_dec_valid;
      if (!rst) begin
         if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, model_fpc);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            model_fpc = model_fpc + 32'd4;
            hs_cnt++;
         end
         if (dec_valid && dec_ready && !redirect) begin
            deq_cnt++;
            chk("sb_nonempty", 32'(exp_pc.size() != 0), 32'd1);
            if (exp_pc.size() != 0) begin
               e_pc   = exp_pc.pop_front();
               e_inst = exp_inst.pop_front();
               chk("dec_pc", dec_pc, e_pc);
               chk("dec_inst", dec_inst, e_inst);
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend_addr.pop_front() ^ KEY;
         void'(pend_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic do_reset();
      imem_req_ready = 1'b0;
      dec_ready      = 1'b0;
      redirect       = 1'b0;
      repeat (4) cycle();
      rst = 1'b1;
      repeat (2) cycle();
      pend_addr.delete();
      pend_due.delete();
      clear_exp();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, h0, found;
      rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b1;
      hi_zero = 1'b0; hi_zero32 = 32'h0;

      // Reset state
      repeat (2) cycle();
      chk("rst_req_valid", s_req_valid, 1'b0);
      chk("rst_dec_valid", s_dec_valid, 1'b0);
      chk("rst_dec_inst", s_dec_inst, 32'h0);
      chk("rst_dec_pc", s_dec_pc, 32'h0);
      chk("rst_hi_req_valid", s_hi_valid, 1'b0);

      // First request and 1/cycle streaming
      rst = 1'b0; model_fpc = 32'h0; push_seq(32'h0, 64);
      cycle();
      chk("first_req_valid", s_req_valid, 1'b1);
      chk("first_req_addr", s_req_addr, 32'h0);
      chk("hi_first_req_valid", s_hi_valid, 1'b1);
      chk("hi_first_req_addr", s_hi_addr, 32'hFFFF_FFF8);
      chk("hi_dec_valid", s_hi_dec_valid, 1'b0);
      cycle();
      chk("fill_latency", s_dec_valid, 1'b0);
      d0 = deq_cnt;
      repeat (16) cycle();
      chk("throughput_16", 32'(deq_cnt - d0), 32'd16);

      // Decode stall: two entries held, no further requests
      do_reset();
      rst = 1'b0; dec_ready = 1'b0; model_fpc = 32'h0; push_seq(32'h0, 40);
      h0 = hs_cnt;
      repeat (12) cycle();
      chk("stall_handshakes", 32'(hs_cnt - h0), 32'd2);
      chk("stall_req_valid", s_req_valid, 1'b0);
      chk("stall_head_valid", s_dec_valid, 1'b1);
      chk("stall_head_pc", s_dec_pc, 32'h0);
      chk("stall_head_inst", s_dec_inst, 32'h0 ^ KEY);
      dec_ready = 1'b1;
      d0 = deq_cnt;
      repeat (3) cycle();
      chk("release_deqs", 32'(deq_cnt - d0), 32'd3);

      // Memory backpressure
      repeat (3) cycle();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_req_valid", s_req_valid, 1'b1);
         chk("bp_req_addr", s_req_addr, model_fpc);
      end
      chk("bp_drained", s_dec_valid, 1'b0);
      imem_req_ready = 1'b1;

      // Redirect coinciding with a response and a dequeue
      repeat (4) cycle();
      redirect = 1'b1; redirect_pc = 32'h200;
      cycle();
      chk("redir_head_valid", s_dec_valid, 1'b1);
      chk("redir_no_req", s_req_valid, 1'b0);
      redirect = 1'b0;
      clear_exp(); push_seq(32'h200, 40); model_fpc = 32'h200;
      cycle();
      chk("redir_dec_cleared", s_dec_valid, 1'b0);
      chk("redir_req_valid", s_req_valid, 1'b1);
      chk("redir_req_addr", s_req_addr, 32'h200);
      repeat (6) cycle();

      // 3-cycle memory: redirect with 0x8 and 0xC in flight
      do_reset();
      lat = 3;
      rst = 1'b0; dec_ready = 1'b1; model_fpc = 32'h0; push_seq(32'h0, 40);
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         cycle();
         if (pend_addr.size() == 2 && pend_addr[0] == 32'h8 && pend_addr[1] == 32'hC) found = 1;
      end
      chk("two_inflight", 32'(found), 32'd1);
      redirect = 1'b1; redirect_pc = 32'h103;
      cycle();
      redirect = 1'b0;
      clear_exp(); push_seq(32'h100, 40); model_fpc = 32'h100;
      cycle();
      chk("drop_dec_cleared", s_dec_valid, 1'b0);
      d0 = deq_cnt;
      for (int i = 0; i < 25 && (deq_cnt - d0) < 2; i++) cycle();
      chk("drop_then_deqs", 32'((deq_cnt - d0) >= 2), 32'd1);

      // Address wrap through an unaligned redirect target
      lat = 1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
      cycle();
      redirect = 1'b0;
      clear_exp(); push_seq(32'hFFFF_FFF8, 16); model_fpc = 32'hFFFF_FFF8;
      d0 = deq_cnt;
      repeat (12) cycle();
      chk("wrap_deqs", 32'((deq_cnt - d0) >= 4), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
